inv_sub_bytes_seq: RTL and testbench
====================================

INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

Interface
REQ-001 The block SHALL have parameter LANES, default 4: bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value SHALL be rejected at elaboration.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream block is presenting a 128-bit state.
REQ-005 The block SHALL have port in_ready, output, 1 bit, registered: the block can accept a state.
REQ-006 The block SHALL have port in_data, input, 128 bits: the state to transform; byte k is in_data[8k+7:8k].
REQ-007 The block SHALL have port out_valid, output, 1 bit, registered: out_data holds a finished result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream block accepts the result.
REQ-009 The block SHALL have port out_data, output, 128 bits, registered: the inverse-SubBytes result, using the same byte order as in_data.
REQ-010 The block SHALL have port flush, input, 1 bit: synchronous abort of any state in flight.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL contain exactly LANES inverse S-box instances; these are the only substitution hardware, shared over time across all 16 bytes.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE, with BEATS = 16/LANES.
REQ-014 In IDLE, in_ready SHALL be 1; a transfer occurs on any edge where in_valid and in_ready are both 1.
- The block captures in_data into a 128-bit state register.
- The beat counter clears to 0.
- in_ready goes to 0.
- The FSM moves to RUN.
REQ-015 In RUN, at each edge, bytes [beat*LANES, beat*LANES+LANES-1] of the state register SHALL be replaced by their inverse S-box values, and the beat counter SHALL increment.
- The lowest bytes are processed first.
- All other bytes are held unchanged.
REQ-016 On the edge that processes beat BEATS-1, the block SHALL move to DONE, set out_valid=1, and load out_data with the fully substituted state.
REQ-017 Latency SHALL be exactly BEATS cycles: out_valid is first high BEATS rising edges after the accepting edge (4 for LANES=4, 1 for LANES=16).
REQ-018 In DONE, out_valid and out_data SHALL hold stable until out_ready=1.
- On that edge out_valid goes to 0, in_ready goes to 1, and the FSM moves to IDLE.
- out_data retains its last value.
REQ-019 in_ready SHALL be 0 in RUN and DONE; there is no overlap between transforms, so the minimum initiation interval is BEATS+2 cycles.
REQ-020 in_valid SHALL be ignored whenever in_ready=0, and in_data SHALL be sampled only on the accepting edge.
REQ-021 flush=1 at an edge in any state SHALL force IDLE with in_ready=1, out_valid=0 and the beat counter at 0.
- Any in-flight state is discarded.
- flush has priority over acceptance, beat processing and output handshake on the same edge.
REQ-022 If out_ready is already 1 when out_valid rises, the result SHALL be consumed on the next edge, giving exactly one cycle of out_valid.
REQ-023 busy SHALL equal 1 in RUN and DONE, and 0 in IDLE and during reset.
REQ-024 The beat counter SHALL be ceil(log2(BEATS)) bits wide, minimum 1, and SHALL never wrap past BEATS-1 inside RUN.

Reset
REQ-025 While rst_n=0, the block SHALL immediately, without waiting for a clock edge, force:
- FSM to IDLE.
- in_ready=0, out_valid=0, busy=0.
- out_data=128'h0, state register=0, beat counter=0.
REQ-026 in_ready SHALL rise to 1 on the first rising clk edge after rst_n deasserts.
REQ-027 Reset asserted mid-RUN or mid-DONE SHALL abandon the transform; no out_valid pulse SHALL follow after reset is released.

Verification
REQ-028 Scenario: LANES=4, in_data = sixteen bytes of 0x63, out_ready=1 -> out_valid high exactly 4 cycles after acceptance, out_data=128'h0, one cycle of out_valid.
REQ-029 Scenario: in_data = bytes 0x7b,0x77,0x7c,0x63 repeated (MSB to LSB) -> out_data = bytes 0x03,0x02,0x01,0x00 repeated; in_data=128'h0 -> every byte 0x52.
REQ-030 Scenario: out_ready held at 0 for 10 cycles in DONE -> out_valid and out_data stay stable, in_ready stays 0, and a new in_valid is not accepted.
REQ-031 Scenario: flush asserted on the 2nd RUN edge -> IDLE on the next edge, in_ready=1, and no out_valid pulse; the next transform still completes correctly.
REQ-032 Scenario: rst_n pulsed low asynchronously mid-RUN -> outputs go to reset values without a clock edge, in_ready=1 one edge after release, and no stale result appears.
REQ-033 Scenario: LANES=1 and LANES=16 builds with a random 128-bit state -> latency of 16 and 1 cycles respectively, and results match the reference inverse S-box model.

Source files
------------

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES inverse SubBytes: LANES inverse S-boxes are time-shared across the 16 state
// bytes, lowest bytes first, with a valid/ready handshake on both sides.
module inv_sub_bytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    input  logic         flush,
    output logic         busy
);

    localparam int unsigned BEATS = 16 / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Inverse affine map followed by GF(2^8) inversion computed as t^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t, r, e;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        e = 8'hfe;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (e[i]) r = gf_mul(r, t);
        end
        return r;
    endfunction

    logic [1:0]    fsm_q, fsm_d;
    logic [127:0]  state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [127:0]  out_data_q, out_data_d;
    logic [7:0]    sbox_out [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] lane_in;
        assign lane_in     = state_q[(int'(beat_q) * LANES + l) * 8 +: 8];
        assign sbox_out[l] = inv_sbox(lane_in);
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        beat_d      = beat_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (fsm_q)
            StIdle: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    state_d    = in_data;
                    beat_d     = '0;
                    in_ready_d = 1'b0;
                    fsm_d      = StRun;
                end
            end
            StRun: begin
                for (int l = 0; l < LANES; l++) begin
                    state_d[(int'(beat_q) * LANES + l) * 8 +: 8] = sbox_out[l];
                end
                if (beat_q == BW'(BEATS - 1)) begin
                    beat_d      = '0;
                    fsm_d       = StDone;
                    out_valid_d = 1'b1;
                    out_data_d  = state_d;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    fsm_d       = StIdle;
                end
            end
            default: begin
                fsm_d       = StIdle;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
        // Flush outranks every other action on the same edge.
        if (flush) begin
            fsm_d       = StIdle;
            beat_d      = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            beat_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            beat_q      <= beat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (fsm_q != StIdle);

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: LANES=4, 1 and 16 instances checked against
// hand-computed vectors and a brute-force inverse S-box table.
module tb_inv_sub_bytes_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         flush     [3];
    logic         busy      [3];

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] inv_tbl [256];

    inv_sub_bytes_seq #(.LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .flush(flush[0]), .busy(busy[0])
    );
    inv_sub_bytes_seq #(.LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .flush(flush[1]), .busy(busy[1])
    );
    inv_sub_bytes_seq #(.LANES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .flush(flush[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    // Forward S-box from a brute-force field inverse, then inverted by table.
    task automatic build_table();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_model(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tbl[d[8*k +: 8]];
        return r;
    endfunction

    // Called at #1 after a rising edge; returns after the accepting edge (+#1).
    task automatic send(input int idx, input logic [127:0] d);
        check($sformatf("rdy_before_send%0d", idx), 128'(in_ready[idx]), 128'h1);
        in_valid[idx] = 1'b1;
        in_data[idx]  = d;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        in_data[idx]  = '0;
    endtask

    task automatic wait_out(input int idx, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid[idx]) break;
        end
    endtask

    task automatic run_one(input int idx, input string tag, input logic [127:0] d,
                           input logic [127:0] exp, input int exp_lat);
        int lat;
        send(idx, d);
        wait_out(idx, lat);
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_data"}, out_data[idx], exp);
        @(posedge clk); #1;
        check({tag, "_onecycle"}, 128'(out_valid[idx]), 128'h0);
        check({tag, "_rdy_after"}, 128'(in_ready[idx]), 128'h1);
    endtask

    initial begin
        logic [127:0] rnd;
        int lat;
        int seen;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1; flush[i] = 1'b0;
        end
        build_table();
        rst_n = 1'b0;
        #23;
        check("rst_in_ready", 128'(in_ready[0]), 128'h0);
        check("rst_out_valid", 128'(out_valid[0]), 128'h0);
        check("rst_busy", 128'(busy[0]), 128'h0);
        check("rst_out_data", out_data[0], 128'h0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_rst", 128'(in_ready[0]), 128'h1);

        run_one(0, "all63", {16{8'h63}}, 128'h0, 4);
        run_one(0, "pattern", {4{32'h7b777c63}}, {4{32'h03020100}}, 4);
        run_one(0, "zero", 128'h0, {16{8'h52}}, 4);

        // Stall in DONE while a competing request is presented.
        out_ready[0] = 1'b0;
        send(0, {4{32'h7b777c63}});
        wait_out(0, lat);
        check("stall_lat", 128'(lat), 128'd4);
        in_valid[0] = 1'b1;
        in_data[0]  = {16{8'haa}};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 128'(out_valid[0]), 128'h1);
            check("stall_data", out_data[0], {4{32'h03020100}});
            check("stall_rdy", 128'(in_ready[0]), 128'h0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("release_valid", 128'(out_valid[0]), 128'h0);
        check("release_not_accepted", 128'(busy[0]), 128'h0);
        check("release_data_kept", out_data[0], {4{32'h03020100}});

        // Flush on the second RUN edge.
        send(0, {16{8'h11}});
        @(posedge clk); #1;
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        check("flush_rdy", 128'(in_ready[0]), 128'h1);
        check("flush_busy", 128'(busy[0]), 128'h0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid[0]) seen++;
            @(posedge clk); #1;
        end
        check("flush_no_valid", 128'(seen), 128'h0);
        run_one(0, "after_flush", 128'h0, {16{8'h52}}, 4);

        // Asynchronous reset mid-RUN.
        send(0, {4{32'h7b777c63}});
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_rdy", 128'(in_ready[0]), 128'h0);
        check("arst_busy", 128'(busy[0]), 128'h0);
        check("arst_valid", 128'(out_valid[0]), 128'h0);
        check("arst_data", out_data[0], 128'h0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_rdy_release", 128'(in_ready[0]), 128'h1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid[0]) seen++;
            @(posedge clk); #1;
        end
        check("arst_no_stale", 128'(seen), 128'h0);
        check("arst_data_clear", out_data[0], 128'h0);

        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_one(0, "rand_l4", rnd, ref_model(rnd), 4);
        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_one(1, "rand_l1", rnd, ref_model(rnd), 16);
        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_one(2, "rand_l16", rnd, ref_model(rnd), 1);
        run_one(1, "pattern_l1", {4{32'h7b777c63}}, {4{32'h03020100}}, 16);
        run_one(2, "zero_l16", 128'h0, {16{8'h52}}, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
